// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if: request/activity handshake and gating status between a clock domain and its gate controller
interface clk_gate_ctrl_if;
    logic test_en_i;
    logic busy_i;
    logic req_i;
    logic ack_o;
    logic clk_en_o;
    logic gated_o;

    modport slave (input test_en_i, busy_i, req_i, output ack_o, clk_en_o, gated_o);
    modport master (output test_en_i, busy_i, req_i, input ack_o, clk_en_o, gated_o);
endinterface

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: gates a downstream clock after a run of idle cycles and ungates it with a settling delay on demand
module clk_gate_ctrl #(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2
) (
    input logic clk_i,
    input logic rst_ni,
    clk_gate_ctrl_if.slave bus
);
    localparam int MaxIw = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
    localparam int CntWidth = $clog2((MaxIw > 2) ? MaxIw : 2);
    localparam logic [CntWidth-1:0] IdleLoad = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLoad = CntWidth'((WakeCycles > 0) ? WakeCycles - 1 : 0);

    typedef enum logic [1:0] {RUN, IDLE_CNT, GATED, WAKE} state_t;

    state_t state;
    logic [CntWidth-1:0] cnt;
    logic active;

    assign active = bus.busy_i | bus.req_i;
    assign bus.clk_en_o = (state != GATED) | bus.test_en_i;
    assign bus.ack_o = (state == RUN) & bus.req_i;
    assign bus.gated_o = (state == GATED);

    // Idle countdown to gating, and a non-abortable settling countdown after ungating
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
            cnt <= '0;
        end else begin
            case (state)
                RUN: if (!active) begin
                    state <= IDLE_CNT;
                    cnt <= IdleLoad;
                end
                IDLE_CNT: if (active) begin
                    state <= RUN;
                    cnt <= '0;
                end else if (cnt == '0) begin
                    state <= GATED;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                GATED: if (active) begin
                    state <= (WakeCycles == 0) ? RUN : WAKE;
                    cnt <= WakeLoad;
                end
                WAKE: if (cnt == '0) begin
                    state <= RUN;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    state <= RUN;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IdleCycles, default 16, means consecutive idle cycles before the clock is gated; legal range >= 1.
REQ-002 Parameter WakeCycles, default 2, means settling cycles after ungating before ack_o may assert; legal range >= 0.
REQ-003 clk_i  input  1  free-running clock; the controller itself is never gated.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 test_en_i  input  1  test mode; forces clk_en_o high.
REQ-006 busy_i  input  1  downstream domain activity; high means the clock is needed.
REQ-007 req_i  input  1  wake/access request; held high until ack_o is seen.
REQ-008 ack_o  output  1  clock running and settled; request granted.
REQ-009 clk_en_o  output  1  enable driving the en_i input of a clock-gating cell.
REQ-010 gated_o  output  1  status; high while in GATED.

Function
REQ-011 The FSM SHALL have exactly four states: RUN, IDLE_CNT, GATED and WAKE.
REQ-012 The down-counter SHALL be CntWidth = $clog2(max(IdleCycles, WakeCycles, 2)) bits wide, and SHALL never underflow.
REQ-013 RUN: if busy_i=0 and req_i=0 at an edge, the FSM SHALL go to IDLE_CNT and load cnt=IdleCycles-1; otherwise it SHALL stay in RUN.
REQ-014 IDLE_CNT: busy_i=1 or req_i=1 SHALL return the FSM to RUN, with cnt cleared; this has priority over expiry.
REQ-015 IDLE_CNT: otherwise, cnt=0 SHALL go to GATED, and cnt>0 SHALL decrement; IDLE_CNT therefore lasts exactly IdleCycles cycles.
REQ-016 GATED: busy_i=1 or req_i=1 SHALL go to WAKE with cnt=WakeCycles-1; if WakeCycles=0, it SHALL go directly to RUN.
REQ-017 WAKE: cnt=0 SHALL go to RUN, and cnt>0 SHALL decrement; WAKE lasts exactly WakeCycles cycles and is never aborted, even if busy_i and req_i drop.
REQ-018 clk_en_o SHALL equal (state != GATED) OR test_en_i, with no combinational path from busy_i or req_i.
REQ-019 ack_o SHALL equal (state == RUN) AND req_i, and SHALL never be high in IDLE_CNT, GATED or WAKE.
REQ-020 gated_o SHALL equal (state == GATED).
REQ-021 test_en_i SHALL NOT alter FSM state or counter; only clk_en_o is overridden.
REQ-022 With busy_i and req_i both toggling every cycle in RUN, the FSM SHALL oscillate between RUN and IDLE_CNT and SHALL never reach GATED.
REQ-023 Gating latency: first idle sample at edge e0 SHALL yield clk_en_o=0 after edge e0+IdleCycles.
REQ-024 Wake latency: request sampled in GATED at edge w SHALL raise clk_en_o after edge w and ack_o after edge w+WakeCycles.

Reset
REQ-025 While rst_ni=0, the block SHALL hold state=RUN, cnt=0, clk_en_o=1, gated_o=0 and ack_o=req_i, applied asynchronously.
REQ-026 Reset asserted in any state, including mid-WAKE or GATED, SHALL immediately force the REQ-025 values; release SHALL take effect on the next clk_i edge.
REQ-027 The first edge after reset release SHALL be evaluated as RUN.

Verification
REQ-028 IdleCycles=4: busy_i=0 and req_i=0 from edge 0 -> clk_en_o=1 through edge 3, clk_en_o=0 and gated_o=1 after edge 4.
REQ-029 IdleCycles=4: busy_i pulse at edge 2 of the idle count -> FSM returns to RUN, and a fresh 4-cycle count is required before gating.
REQ-030 WakeCycles=2, GATED: req_i=1 at edge w -> clk_en_o=1 after w, ack_o=0 after w+1, ack_o=1 after w+2.
REQ-031 WakeCycles=0, GATED: busy_i=1 at edge w -> RUN after w, and clk_en_o=1 with gated_o=0 in the same cycle.
REQ-032 GATED with test_en_i=1 -> clk_en_o=1 while gated_o stays 1; releasing test_en_i -> clk_en_o=0.
REQ-033 rst_ni=0 asserted mid-WAKE -> clk_en_o=1, gated_o=0 and state=RUN immediately; after release, an idle stimulus regates after IdleCycles+1 edges.
